// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and enums shared by the 16-bit ALU and the mul/div sequencer.
//   ALU_*        ALU opcode encodings (3 bits)
//   seq_op_t     sequencer command (MUL / DIVU)
//   seq_state_t  sequencer control state
package alu_pkg;

  localparam int unsigned ALU_W    = 16;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_NOT = 3'h0;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'h1;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'h2;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'h3;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'h4;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'h5;
  localparam logic [ALU_OP_W-1:0] ALU_MOV = 3'h6;

  typedef enum logic {
    SEQ_MUL  = 1'b0,
    SEQ_DIVU = 1'b1
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle unsigned multiply / divide sequencer driving the shared ALU.
// One iteration per RUN cycle: shift-add for MUL, restoring subtract for DIVU.
//
// Build option: define ALU_SEQ_DIV_EN to include the divide datapath. Without it
// an accepted DIVU completes immediately with resp_err = 1 and a zero result.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req_valid/req_ready   command handshake (req_ready high only in IDLE)
//   req_op, req_a, req_b  0 = MUL a*b, 1 = DIVU a/b
//   resp_valid/resp_ready result handshake, resp_* held until accepted
//   resp_hi, resp_lo      product[31:16]/[15:0] or remainder/quotient
//   resp_dbz, resp_err    divide by zero, unsupported op
//   busy                  high while iterating (parent muxes ALU inputs to us)
//   alu_a, alu_b, alu_op  ALU operand/opcode drive, decoded from registers only
//   alu_override(_en)     tied to 0
//   alu_agg, alu_C        ALU result and carry/borrow
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W  // only 16 is supported
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [WIDTH-1:0]    req_a,
  input  logic [WIDTH-1:0]    req_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WIDTH-1:0]    resp_hi,
  output logic [WIDTH-1:0]    resp_lo,
  output logic                resp_dbz,
  output logic                resp_err,
  output logic                busy,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [WIDTH-1:0]    alu_override,
  output logic                alu_override_en,
  input  logic [WIDTH-1:0]    alu_agg,
  input  logic                alu_C
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  seq_state_t        state_q, state_d;
  seq_op_t           op_q, op_d;
  logic [WIDTH-1:0]  b_q, b_d;        // multiplicand / divisor
  logic [WIDTH-1:0]  hi_q, hi_d;      // product high / remainder
  logic [WIDTH-1:0]  lo_q, lo_d;      // multiplier-product low / quotient
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dbz_q, dbz_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              busy_q, busy_d;

`ifdef ALU_SEQ_DIV_EN
  // Restoring-divide step: shifted partial remainder and its dropped 17th bit.
  // A set 17th bit means the remainder already exceeds any 16-bit divisor.
  logic [WIDTH-1:0] div_rs;
  logic             div_q;

  always_comb begin
    div_rs = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    div_q  = hi_q[WIDTH-1] | ~alu_C;
  end
`endif

  // ALU drive: idle operands and MOV outside RUN
  always_comb begin
    alu_op = ALU_MOV;
    alu_a  = '0;
    alu_b  = '0;
    if (state_q == ST_RUN) begin
      if (op_q == SEQ_MUL) begin
        alu_op = ALU_ADD;
        alu_a  = hi_q;
        alu_b  = lo_q[0] ? b_q : '0;
      end
`ifdef ALU_SEQ_DIV_EN
      else begin
        alu_op = ALU_SUB;
        alu_a  = div_rs;
        alu_b  = b_q;
      end
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d  = seq_op_t'(req_op);
          b_d   = req_b;
          cnt_d = '0;
          dbz_d = 1'b0;
          err_d = 1'b0;
          if (seq_op_t'(req_op) == SEQ_MUL) begin
            hi_d    = '0;
            lo_d    = req_a;
            state_d = ST_RUN;
          end else begin
`ifdef ALU_SEQ_DIV_EN
            if (req_b == '0) begin
              hi_d    = req_a;
              lo_d    = '1;
              dbz_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              hi_d    = '0;
              lo_d    = req_a;
              state_d = ST_RUN;
            end
`else
            hi_d    = '0;
            lo_d    = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
`endif
          end
        end
      end

      ST_RUN: begin
        if (op_q == SEQ_MUL) begin
          // 33-bit {carry, sum, multiplier} shifted right by one
          {hi_d, lo_d} = {alu_C, alu_agg, lo_q[WIDTH-1:1]};
        end
`ifdef ALU_SEQ_DIV_EN
        else begin
          hi_d = div_q ? alu_agg : div_rs;
          lo_d = {lo_q[WIDTH-2:0], div_q};
        end
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (resp_ready) begin
          dbz_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake/status flags track the next state so they are registered outputs
  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
    busy_d       = (state_d == ST_RUN);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= SEQ_MUL;
      b_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      dbz_q        <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      dbz_q        <= dbz_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign busy            = busy_q;
  assign resp_hi         = hi_q;
  assign resp_lo         = lo_q;
  assign resp_dbz        = dbz_q;
  assign resp_err        = err_q;
  assign alu_override    = '0;
  assign alu_override_en = 1'b0;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq. Provides the parent's ALU,
// applies a vector table, hand-written multi-cycle sequences and random
// commands checked against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_op;
  logic [15:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_hi, resp_lo;
  logic        resp_dbz, resp_err, busy;
  logic [15:0] alu_a, alu_b, alu_override, alu_agg;
  logic [2:0]  alu_op;
  logic        alu_override_en, alu_C;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo),
    .resp_dbz(resp_dbz), .resp_err(resp_err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_override(alu_override), .alu_override_en(alu_override_en),
    .alu_agg(alu_agg), .alu_C(alu_C)
  );

  // Parent-side ALU
  always_comb begin
    alu_agg = '0;
    alu_C   = 1'b0;
    case (alu_op)
      ALU_NOT: alu_agg = ~alu_a;
      ALU_AND: alu_agg = alu_a & alu_b;
      ALU_OR:  alu_agg = alu_a | alu_b;
      ALU_XOR: alu_agg = alu_a ^ alu_b;
      ALU_ADD: {alu_C, alu_agg} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: begin
        alu_agg = alu_a - alu_b;
        alu_C   = (alu_a < alu_b);
      end
      ALU_MOV: alu_agg = alu_b;
      default: alu_agg = '0;
    endcase
  end

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    logic        err;
    int          lat;
    int          bp;
  } vec_t;

  // Reference model: plain arithmetic on the command
  function automatic vec_t model(input logic op, input logic [15:0] a, input logic [15:0] b,
                                 input int bp);
    vec_t        v;
    logic [31:0] p;
    v.op = op; v.a = a; v.b = b; v.bp = bp;
    v.dbz = 1'b0; v.err = 1'b0;
    if (!op) begin
      p    = 32'(a) * 32'(b);
      v.hi = p[31:16];
      v.lo = p[15:0];
      v.lat = 17;
    end else if (!DIV_EN) begin
      v.hi = '0; v.lo = '0; v.err = 1'b1; v.lat = 1;
    end else if (b == 16'h0) begin
      v.hi = a; v.lo = 16'hFFFF; v.dbz = 1'b1; v.lat = 1;
    end else begin
      v.hi = a % b; v.lo = a / b; v.lat = 17;
    end
    return v;
  endfunction

  // Fixed expectation for a divide vector; collapses to the error response when divide is absent
  function automatic vec_t div_vec(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] hi, input logic [15:0] lo,
                                   input logic dbz, input int lat, input int bp);
    vec_t v;
    v.op = 1'b1; v.a = a; v.b = b; v.bp = bp;
    if (DIV_EN) begin
      v.hi = hi; v.lo = lo; v.dbz = dbz; v.err = 1'b0; v.lat = lat;
    end else begin
      v.hi = '0; v.lo = '0; v.dbz = 1'b0; v.err = 1'b1; v.lat = 1;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One command from IDLE through acceptance; entered and left on a negedge
  task automatic run_txn(input vec_t v);
    int          cyc;
    logic [15:0] shi, slo;
    logic        sd, se;
    check("req_ready_idle", 32'(req_ready), 32'(1));
    check("alu_op_idle", 32'(alu_op), 32'(ALU_MOV));
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom); req_op = 1'($urandom);
    cyc = 1;
    if (v.lat > 1) begin
      check("busy_run", 32'(busy), 32'(1));
      check("req_ready_run", 32'(req_ready), 32'(0));
      check("alu_op_run", 32'(alu_op), v.op ? 32'(ALU_SUB) : 32'(ALU_ADD));
      check("alu_override", {15'd0, alu_override_en, alu_override}, 32'(0));
    end
    while (!resp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(v.lat));
    check("resp_hi", 32'(resp_hi), 32'(v.hi));
    check("resp_lo", 32'(resp_lo), 32'(v.lo));
    check("resp_flags", {30'd0, resp_dbz, resp_err}, {30'd0, v.dbz, v.err});
    check("done_status", {30'd0, busy, req_ready}, 32'(0));
    shi = resp_hi; slo = resp_lo; sd = resp_dbz; se = resp_err;
    for (int i = 0; i < v.bp; i++) begin
      @(negedge clk);
      check("bp_stable", {resp_valid, req_ready, resp_dbz, resp_err, resp_hi, resp_lo[11:0]},
            {1'b1, 1'b0, sd, se, shi, slo[11:0]});
      check("bp_lo", 32'(resp_lo), 32'(slo));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_accept", {28'd0, resp_valid, req_ready, resp_dbz, resp_err}, 32'h4);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t        v;
    int          hs, t0, t1, cyc;
    bit          seen;

    reset_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; resp_ready = 1'b0;

    // Reset state
    #12;
    check("reset_outs", {busy, resp_valid, req_ready, resp_dbz, resp_err, alu_override_en, resp_hi, 10'd0},
          32'(0));
    check("reset_lo", 32'(resp_lo), 32'(0));
    check("reset_alu", {alu_a, alu_b}, 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", 32'(req_ready), 32'(1));

    // Directed vector table
    vecs[0] = model(1'b0, 16'h0003, 16'h0005, 0);
    vecs[0].hi = 16'h0000; vecs[0].lo = 16'h000F;
    vecs[1] = model(1'b0, 16'hFFFF, 16'hFFFF, 0);
    vecs[1].hi = 16'hFFFE; vecs[1].lo = 16'h0001;
    vecs[2] = div_vec(16'd100, 16'd7, 16'h0002, 16'h000E, 1'b0, 17, 5);
    vecs[3] = div_vec(16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17, 0);
    vecs[4] = div_vec(16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1, 5);
    vecs[5] = model(1'b0, 16'h00FF, 16'h0101, 5);
    vecs[5].hi = 16'h0000; vecs[5].lo = 16'hFFFF;
    vecs[6] = model(1'b0, 16'h8000, 16'h0002, 0);
    vecs[6].hi = 16'h0001; vecs[6].lo = 16'h0000;
    vecs[7] = model(1'b0, 16'h0000, 16'hFFFF, 0);
    vecs[7].hi = 16'h0000; vecs[7].lo = 16'h0000;
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Back-to-back throughput with resp_ready held high
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 1'b0; req_a = 16'h0003; req_b = 16'h0005;
    hs = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 60 && hs < 2; c++) begin
      if (req_ready) begin
        if (hs == 0) t0 = c; else t1 = c;
        hs++;
      end
      if (hs < 2) @(negedge clk);
    end
    check("throughput_hs", 32'(hs), 32'(2));
    check("throughput_gap", 32'(t1 - t0), 32'(18));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_latency", 32'(cyc), 32'(17));
    check("b2b_result", {resp_hi, resp_lo}, 32'h0000000F);
    @(negedge clk);
    resp_ready = 1'b0;
    check("b2b_idle", {30'd0, resp_valid, req_ready}, 32'h1);

    // Reset during RUN cycle 8 aborts with no response
    req_valid = 1'b1; req_op = 1'b0; req_a = 16'h1234; req_b = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'(1));
    reset_n = 1'b0;
    #1;
    check("abort_outs", {busy, resp_valid, req_ready, resp_dbz, resp_err, 11'd0, resp_hi}, 32'(0));
    check("abort_lo", 32'(resp_lo), 32'(0));
    check("abort_alu", {alu_a, alu_b}, 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_ready", {30'd0, resp_valid, req_ready}, 32'h1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("abort_no_resp", 32'(seen), 32'(0));
    v = model(1'b0, 16'h0002, 16'h0002, 0);
    v.hi = 16'h0000; v.lo = 16'h0004;
    run_txn(v);

    // Random commands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic        op;
      logic [15:0] a, b;
      op = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'hFFFF;
      run_txn(model(op, a, b, int'($urandom_range(0, 2))));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle multiply/divide sequencer for the 16-bit ALU. Accepts one MUL or DIVU command through a valid/ready handshake, then drives the ALU's operand and opcode inputs for one iteration per cycle: shift-add for multiply, restoring subtract for divide. It returns a 32-bit product or a quotient/remainder pair through a second valid/ready handshake. It sits beside the ALU in the execute stage, and the CPU control muxes ALU inputs to this block while `busy` is high.

## Interface
- `WIDTH`, 16, operand width and iteration count; only 16 is supported (matches ALU)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `req_valid`  in  1  command valid
- `req_ready`  out  1  high only in IDLE
- `req_op`  in  1  0 = MUL (unsigned), 1 = DIVU (unsigned)
- `req_a`  in  16  multiplier / dividend
- `req_b`  in  16  multiplicand / divisor
- `resp_valid`  out  1  result valid, held until accepted
- `resp_ready`  in  1  consumer accepts result
- `resp_hi`  out  16  product[31:16] / remainder
- `resp_lo`  out  16  product[15:0] / quotient
- `resp_dbz`  out  1  divide by zero
- `resp_err`  out  1  unsupported op (DIVU when divide compiled out)
- `busy`  out  1  high in RUN
- `alu_a`, `alu_b`  out  16  ALU operands
- `alu_op`  out  3  ALU opcode
- `alu_override`  out  16  constant 0
- `alu_override_en`  out  1  constant 0
- `alu_agg`  in  16  ALU result
- `alu_C`  in  1  ALU carry (ADD: carry out; SUB: borrow, 1 when a < b)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. All registers and outputs are 0 at reset, including `req_ready`. `req_ready` is 1 from the first cycle after reset deasserts.
- IDLE: on `req_valid & req_ready`, latch op, a, b and clear `cnt`. MUL: {hi,lo} = {0, a}, go to RUN. DIVU with b ≠ 0: rem = 0, quo = a, go to RUN. DIVU with b = 0: hi = a, lo = FFFF, dbz = 1, go to DONE.
- RUN MUL, per cycle: `alu_op` = ADD, `alu_a` = hi, `alu_b` = lo[0] ? mcand : 0. Update {hi,lo} ← {alu_C, alu_agg, lo} >> 1, taking the upper 32 of 33 bits.
- RUN DIVU, per cycle: rs = {rem[14:0], quo[15]}, r16 = rem[15]. `alu_op` = SUB, `alu_a` = rs, `alu_b` = divisor. Set q = r16 | ~alu_C. Then rem ← q ? alu_agg : rs, and quo ← {quo[14:0], q}.
- `cnt` increments each RUN cycle. When `cnt` = WIDTH−1 the iteration completes and the state goes to DONE.
- Outside RUN: `alu_op` = MOV (3'h6), `alu_a` = `alu_b` = 0.
- DONE: `resp_valid` = 1 with stable `resp_*`. On `resp_ready`, go to IDLE and clear dbz/err. `req_ready` stays 0 during the accept cycle.
- `reset_n` low mid-operation aborts immediately to IDLE. The in-flight result is discarded and no response is produced.

## Timing
- Handshake at edge T: RUN covers cycles T+1…T+16, and `resp_valid` rises at T+17.
- Divide by zero or `resp_err`: `resp_valid` rises at T+1.
- Back-to-back throughput is one command per 18 cycles with `resp_ready` held high.
- The ALU path is combinational within a RUN cycle; `alu_*` outputs are decoded from registers only.
- `resp_*` do not change while `resp_valid & ~resp_ready`.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIVU is implemented as above.
- Undefined: the divide datapath is removed. An accepted DIVU goes to DONE at T+1 with `resp_err` = 1 and `resp_hi` = `resp_lo` = 0. MUL is unaffected.

## Structure
- Shared package `alu_pkg`: ALU opcode localparams (NOT 0, AND 1, OR 2, XOR 3, ADD 4, SUB 5, MOV 6), the `seq_op_t` enum (MUL, DIVU), and the `seq_state_t` enum.
- Single module, no sub-module. The ALU is instantiated by the parent, not inside this block.

## Test plan
- MUL 3 × 5 → `resp_hi` = 0000, `resp_lo` = 000F, `resp_valid` at T+17; FFFF × FFFF → FFFE / 0001.
- DIVU 100 / 7 → quotient 000E, remainder 0002; FFFF / 8001 (r16 path) → quotient 0001, remainder 7FFE.
- DIVU 1234 / 0 → `resp_dbz` = 1, lo = FFFF, hi = 1234, `resp_valid` at T+1.
- Backpressure: hold `resp_ready` = 0 for 5 cycles in DONE → outputs stable, `req_ready` = 0; release → IDLE next cycle, and a new request accepted then completes correctly.
- Assert `reset_n` low at RUN cycle 8, release → all outputs 0, `req_ready` = 1, no `resp_valid`; a following MUL 2 × 2 → 0000 / 0004.
- Build without `ALU_SEQ_DIV_EN`: DIVU 100 / 7 → `resp_err` = 1, hi = lo = 0 at T+1.
